uart_out_arbiter: RTL and testbench

//  Shares the single outbound UART message path (msg_disasm FIFO write port) between
//  NUM_REQ message sources, e.g. controller replies, mem_manager event reports and a

---
 rtl/uart_out_arbiter_pkg.sv | 15 +
 rtl/uart_out_arbiter_rr_pick.sv | 31 +++
 rtl/uart_out_arbiter.sv | 116 +++++++++++
 tb/tb_uart_out_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_out_arbiter_pkg.sv
// Shared constants for the outbound UART message path and its arbiter.
//  UART_MSG_WIDTH : packet width in bits written into msg_disasm_fifo
//  UART_MSG_SIZE  : packet width in bytes
//  arb_state_e    : arbiter FSM encodings (IDLE decides, ISSUE strobes)
package uart_out_arbiter_pkg;

    localparam int unsigned UART_MSG_WIDTH = 32;
    localparam int unsigned UART_MSG_SIZE  = UART_MSG_WIDTH / 8;

    typedef enum logic {
        ARB_STATE_IDLE  = 1'b0,
        ARB_STATE_ISSUE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/uart_out_arbiter_rr_pick.sv
// Combinational round-robin picker.
//  eligible : per-requester candidate bits
//  last     : index of the most recent grant; search starts at last+1 and wraps
//  any_c    : at least one candidate present
//  idx_c    : first eligible index after last (0 when none)
module uart_out_arbiter_rr_pick #(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   last,
    output logic               any_c,
    output logic [IDX_W-1:0]   idx_c
);

    logic [IDX_W-1:0] cand;

    // Walk the rotation backwards so the last hit is the earliest candidate.
    always_comb begin
        any_c = |eligible;
        idx_c = '0;
        cand  = '0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            cand = IDX_W'((int'(last) + k) % int'(NUM_REQ));
            if (eligible[cand]) begin
                idx_c = cand;
            end
        end
    end

endmodule

// File: rtl/uart_out_arbiter.sv
// Round-robin arbiter sharing the msg_disasm FIFO write port between NUM_REQ
// message producers; one whole packet per grant, at most one write per 2 cycles.
//  clk, n_reset : system clock, asynchronous active-low reset
//  req_valid    : per-requester packet pending
//  req_msg      : packets, requester i at [i*MSG_WIDTH +: MSG_WIDTH]
//  req_ack      : one-cycle pulse, packet i taken
//  out_full     : downstream FIFO full (sampled only when deciding)
//  out_msg      : packet to FIFO data_in
//  out_wr_en    : one-cycle FIFO write strobe
//  busy         : high during the issue cycle
//  last_gnt     : index of the most recent rotating grant
module uart_out_arbiter
    import uart_out_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ     = 2,
    parameter  int unsigned MSG_WIDTH   = UART_MSG_WIDTH,
    parameter  bit          PRIO0_FIXED = 1'b0,
    localparam int unsigned IDX_W       = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         n_reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*MSG_WIDTH-1:0] req_msg,
    output logic [NUM_REQ-1:0]           req_ack,
    input  logic                         out_full,
    output logic [MSG_WIDTH-1:0]         out_msg,
    output logic                         out_wr_en,
    output logic                         busy,
    output logic [IDX_W-1:0]             last_gnt
);

    arb_state_e           state_q, state_d;
    logic [NUM_REQ-1:0]   mask_q, mask_d;
    logic [NUM_REQ-1:0]   eligible_c, win_onehot_c;
    logic [IDX_W-1:0]     rr_idx_c, win_c, last_d;
    logic                 rr_any_c;
    logic [NUM_REQ-1:0]   req_ack_d;
    logic [MSG_WIDTH-1:0] out_msg_d;
    logic                 out_wr_en_d, busy_d;
    logic [MSG_WIDTH-1:0] msg_arr [NUM_REQ];

    // Unpacked view so only the winner's slice reaches out_msg.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_msg
        assign msg_arr[g] = req_msg[g*MSG_WIDTH +: MSG_WIDTH];
    end

    // The just-granted requester is masked for one cycle: its valid is still high.
    assign eligible_c   = req_valid & ~mask_q;
    assign win_c        = (PRIO0_FIXED && eligible_c[0]) ? '0 : rr_idx_c;
    assign win_onehot_c = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_c;

    uart_out_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .eligible (eligible_c),
        .last     (last_gnt),
        .any_c    (rr_any_c),
        .idx_c    (rr_idx_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        last_d      = last_gnt;
        out_msg_d   = out_msg;
        req_ack_d   = '0;
        out_wr_en_d = 1'b0;
        busy_d      = 1'b0;
        case (state_q)
            ARB_STATE_IDLE: begin
                mask_d = '0;
                if (!out_full && rr_any_c) begin
                    state_d     = ARB_STATE_ISSUE;
                    out_msg_d   = msg_arr[win_c];
                    mask_d      = win_onehot_c;
                    req_ack_d   = win_onehot_c;
                    out_wr_en_d = 1'b1;
                    busy_d      = 1'b1;
                    // A fixed-priority win for req 0 leaves the others' rotation intact.
                    if (!(PRIO0_FIXED && (win_c == '0))) begin
                        last_d = win_c;
                    end
                end
            end
            ARB_STATE_ISSUE: begin
                state_d = ARB_STATE_IDLE;
            end
            default: begin
                state_d = ARB_STATE_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= ARB_STATE_IDLE;
            mask_q    <= '0;
            last_gnt  <= IDX_W'(NUM_REQ - 1);
            out_msg   <= '0;
            out_wr_en <= 1'b0;
            req_ack   <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            last_gnt  <= last_d;
            out_msg   <= out_msg_d;
            out_wr_en <= out_wr_en_d;
            req_ack   <= req_ack_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_out_arbiter.sv
// Bench for uart_out_arbiter: a 2-requester rotating instance and a
// 3-requester instance with fixed priority on requester 0, checked each cycle
// against a transaction-level model of grants built from packet queues.
module tb_uart_out_arbiter;
    import uart_out_arbiter_pkg::*;

    localparam int unsigned W = UART_MSG_WIDTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         n_reset;
    logic [1:0]   a_valid, a_ack;
    logic [2*W-1:0] a_msg;
    logic         a_full, a_wr, a_busy;
    logic [W-1:0] a_out_msg;
    logic [0:0]   a_last;
    logic [2:0]   b_valid, b_ack;
    logic [3*W-1:0] b_msg;
    logic         b_full, b_wr, b_busy;
    logic [W-1:0] b_out_msg;
    logic [1:0]   b_last;

    uart_out_arbiter #(.NUM_REQ(2), .MSG_WIDTH(W), .PRIO0_FIXED(1'b0)) dut_a (
        .clk(clk), .n_reset(n_reset), .req_valid(a_valid), .req_msg(a_msg),
        .req_ack(a_ack), .out_full(a_full), .out_msg(a_out_msg),
        .out_wr_en(a_wr), .busy(a_busy), .last_gnt(a_last));

    uart_out_arbiter #(.NUM_REQ(3), .MSG_WIDTH(W), .PRIO0_FIXED(1'b1)) dut_b (
        .clk(clk), .n_reset(n_reset), .req_valid(b_valid), .req_msg(b_msg),
        .req_ack(b_ack), .out_full(b_full), .out_msg(b_out_msg),
        .out_wr_en(b_wr), .busy(b_busy), .last_gnt(b_last));

    int n_checks = 0;
    int n_pass   = 0;
    int cur, nreq, cyc;
    bit prio;
    logic full;
    logic [W-1:0] pq [3][$];
    int pop_cnt [3];
    int wr_log [$];
    int wr_cyc [$];

    // Model: one packet in flight, per-requester masking, grant order by rule.
    bit           m_issue;
    int           m_w, m_last;
    logic [2:0]   m_mask;
    logic [W-1:0] m_msg;

    logic         o_wr, o_busy;
    logic [2:0]   o_ack;
    int           o_last;
    logic [W-1:0] o_msg;

    function automatic int pick(logic [2:0] elig, int last, int n, bit p0);
        if (p0 && elig[0]) return 0;
        for (int k = 1; k <= n; k++) begin
            int j = (last + k) % n;
            if (elig[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_issue = 1'b0; m_w = 0; m_last = nreq - 1; m_mask = '0; m_msg = '0;
    endtask

    task automatic drive();
        logic [2:0]     v;
        logic [3*W-1:0] m;
        v = '0;
        m = '0;
        for (int i = 0; i < 3; i++) begin
            if (i < nreq && pq[i].size() > 0) begin
                v[i] = 1'b1;
                m[i*W +: W] = pq[i][0];
            end else begin
                m[i*W +: W] = $urandom;
            end
        end
        if (cur == 0) begin
            a_valid = v[1:0]; a_msg = m[2*W-1:0]; a_full = full;
            b_valid = '0; b_msg = m; b_full = 1'b0;
        end else begin
            b_valid = v; b_msg = m; b_full = full;
            a_valid = '0; a_msg = m[2*W-1:0]; a_full = 1'b0;
        end
    endtask

    task automatic read_out();
        if (cur == 0) begin
            o_wr = a_wr; o_ack = {1'b0, a_ack}; o_busy = a_busy;
            o_last = int'(a_last); o_msg = a_out_msg;
        end else begin
            o_wr = b_wr; o_ack = b_ack; o_busy = b_busy;
            o_last = int'(b_last); o_msg = b_out_msg;
        end
    endtask

    // Advance one clock: update model at the edge, sample DUT #1 later,
    // then let requesters react (hold one cycle after ack, then pop).
    task automatic step(output logic [38:0] act, output logic [38:0] exp);
        logic [2:0] v, elig;
        int w;
        @(posedge clk);
        if (n_reset) begin
            if (m_issue) begin
                m_issue = 1'b0;
            end else begin
                for (int i = 0; i < 3; i++) v[i] = (i < nreq) && (pq[i].size() > 0);
                elig = v & ~m_mask;
                if (!full && elig != 3'b000) begin
                    w = pick(elig, m_last, nreq, prio);
                    m_w = w;
                    m_msg = pq[w][0];
                    if (!(prio && w == 0)) m_last = w;
                    m_mask = 3'(3'b001 << w);
                    m_issue = 1'b1;
                end else begin
                    m_mask = '0;
                end
            end
        end
        #1;
        cyc++;
        read_out();
        act = {o_wr, o_ack, o_busy, 2'(o_last), o_msg};
        exp = {m_issue, (m_issue ? 3'(3'b001 << m_w) : 3'b000), m_issue, 2'(m_last), m_msg};
        if (o_wr) begin
            int idx = -1;
            for (int i = 2; i >= 0; i--) if (o_ack[i]) idx = i;
            wr_log.push_back(idx);
            wr_cyc.push_back(cyc);
        end
        for (int i = 0; i < 3; i++) begin
            if (pop_cnt[i] > 0) begin
                pop_cnt[i]--;
                if (pop_cnt[i] == 0 && pq[i].size() > 0) void'(pq[i].pop_front());
            end
            if (o_ack[i]) pop_cnt[i] = 2;
        end
        drive();
    endtask

    task automatic do_reset(int which);
        cur = which; nreq = (which == 0) ? 2 : 3; prio = (which == 1);
        full = 1'b0;
        for (int i = 0; i < 3; i++) begin pq[i].delete(); pop_cnt[i] = 0; end
        @(negedge clk);
        n_reset = 1'b0;
        model_reset();
        drive();
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        wr_log.delete(); wr_cyc.delete(); cyc = 0;
    endtask

    task automatic test_reset();
        logic [38:0] got, want;
        n_reset = 1'b1; cur = 0; nreq = 2; full = 1'b0;
        drive();
        #3 n_reset = 1'b0;
        #1;
        got  = {a_wr, 1'b0, a_ack, a_busy, 1'b0, a_last, a_out_msg};
        want = {1'b0, 3'b000, 1'b0, 2'd1, 32'h0};
        n_checks++;
        if (got !== want) $display("FAIL reset_a got=%h want=%h", got, want); else n_pass++;
        got  = {b_wr, b_ack, b_busy, b_last, b_out_msg};
        want = {1'b0, 3'b000, 1'b0, 2'd2, 32'h0};
        n_checks++;
        if (got !== want) $display("FAIL reset_b got=%h want=%h", got, want); else n_pass++;
    endtask

    task automatic test_single();
        logic [38:0] act, exp;
        int first;
        do_reset(0);
        pq[0].push_back(32'hA5A5_0001); drive();
        for (int c = 0; c < 6; c++) begin
            step(act, exp);
            n_checks++;
            if (act !== exp) $display("FAIL single cyc%0d got=%h want=%h", c, act, exp); else n_pass++;
        end
        first = (wr_cyc.size() > 0) ? wr_cyc[0] : -1;
        n_checks++;
        if (wr_log.size() !== 1 || first !== 1)
            $display("FAIL single_count writes=%0d first_cyc=%0d want 1/1", wr_log.size(), first);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [38:0] act, exp;
        bit ok;
        do_reset(0);
        for (int k = 0; k < 3; k++) begin
            pq[0].push_back(32'h1000_0000 + W'(k));
            pq[1].push_back(32'h2000_0000 + W'(k));
        end
        drive();
        for (int c = 0; c < 16; c++) begin
            step(act, exp);
            n_checks++;
            if (act !== exp) $display("FAIL b2b cyc%0d got=%h want=%h", c, act, exp); else n_pass++;
        end
        ok = (wr_log.size() == 6);
        for (int k = 0; k < wr_log.size(); k++) begin
            if (wr_log[k] != k % 2) ok = 1'b0;
            if (k > 0 && wr_cyc[k] - wr_cyc[k-1] != 2) ok = 1'b0;
        end
        n_checks++;
        if (!ok) $display("FAIL b2b_order writes=%0d want 6 alternating 2 cycles apart", wr_log.size());
        else n_pass++;
    endtask

    task automatic test_full();
        logic [38:0] act, exp;
        do_reset(0);
        pq[0].push_back(32'h3000_0000); drive();
        for (int c = 0; c < 4; c++) begin
            step(act, exp);
            n_checks++;
            if (act !== exp) $display("FAIL full_pre cyc%0d got=%h want=%h", c, act, exp); else n_pass++;
        end
        full = 1'b1;
        pq[0].push_back(32'h3000_0001); pq[1].push_back(32'h3100_0001);
        drive();
        for (int c = 0; c < 20; c++) begin
            step(act, exp);
            n_checks++;
            if (act !== exp) $display("FAIL full_hold cyc%0d got=%h want=%h", c, act, exp); else n_pass++;
        end
        n_checks++;
        if (wr_log.size() !== 1) $display("FAIL full_nowrite writes=%0d want 1", wr_log.size()); else n_pass++;
        full = 1'b0; drive();
        step(act, exp);
        n_checks++;
        if (act[38:35] !== 4'b1010 || act[31:0] !== 32'h3100_0001)
            $display("FAIL full_release got wr/ack=%b msg=%h want 1010/31000001", act[38:35], act[31:0]);
        else n_pass++;
        for (int c = 0; c < 10; c++) begin
            step(act, exp);
            n_checks++;
            if (act !== exp) $display("FAIL full_drain cyc%0d got=%h want=%h", c, act, exp); else n_pass++;
        end
    endtask

    task automatic test_mask();
        logic [38:0] act, exp;
        do_reset(0);
        pq[1].push_back(32'h4444_0001); drive();
        for (int c = 0; c < 8; c++) begin
            step(act, exp);
            n_checks++;
            if (act !== exp) $display("FAIL mask cyc%0d got=%h want=%h", c, act, exp); else n_pass++;
        end
        n_checks++;
        if (wr_log.size() !== 1) $display("FAIL mask_dup writes=%0d want 1", wr_log.size()); else n_pass++;
    endtask

    task automatic test_prio0();
        logic [38:0] act, exp;
        int zeros, prev;
        bit ok;
        do_reset(1);
        for (int k = 0; k < 3; k++) begin
            pq[0].push_back(32'h5000_0000 + W'(k));
            pq[1].push_back(32'h5100_0000 + W'(k));
            pq[2].push_back(32'h5200_0000 + W'(k));
        end
        drive();
        for (int c = 0; c < 30; c++) begin
            step(act, exp);
            n_checks++;
            if (act !== exp) $display("FAIL prio cyc%0d got=%h want=%h", c, act, exp); else n_pass++;
        end
        zeros = 0; prev = -1;
        ok = (wr_log.size() == 9) && (wr_log.size() > 0) && (wr_log[0] == 0);
        for (int k = 0; k < wr_log.size(); k++) begin
            if (wr_log[k] == 0) zeros++;
            else begin
                if (wr_log[k] == prev) ok = 1'b0;
                prev = wr_log[k];
            end
        end
        n_checks++;
        if (!ok || zeros != 3)
            $display("FAIL prio_order writes=%0d zeros=%0d want 9 with 3 req0, first req0, 1/2 rotating", wr_log.size(), zeros);
        else n_pass++;
    endtask

    task automatic test_reset_mid_issue();
        logic [38:0] act, exp, got, want;
        do_reset(0);
        pq[0].push_back(32'h6000_0000); drive();
        for (int c = 0; c < 4; c++) begin
            step(act, exp);
            n_checks++;
            if (act !== exp) $display("FAIL rmid_pre cyc%0d got=%h want=%h", c, act, exp); else n_pass++;
        end
        pq[0].push_back(32'h6000_0001); pq[1].push_back(32'h6100_0001); drive();
        step(act, exp);
        n_checks++;
        if (act !== exp) $display("FAIL rmid_grant got=%h want=%h", act, exp); else n_pass++;
        #2 n_reset = 1'b0;
        #1;
        got  = {a_wr, a_ack, a_busy, a_last};
        want = {1'b0, 2'b00, 1'b0, 1'b1};
        n_checks++;
        if (got !== want) $display("FAIL rmid_abort got=%b want=%b", got, want); else n_pass++;
        model_reset();
        for (int i = 0; i < 3; i++) pop_cnt[i] = 0;
        drive();
        @(negedge clk);
        n_reset = 1'b1;
        step(act, exp);
        n_checks++;
        if (act[38:35] !== 4'b1001 || act[31:0] !== 32'h6000_0001)
            $display("FAIL rmid_after got wr/ack=%b msg=%h want 1001/60000001", act[38:35], act[31:0]);
        else n_pass++;
        for (int c = 0; c < 10; c++) begin
            step(act, exp);
            n_checks++;
            if (act !== exp) $display("FAIL rmid_drain cyc%0d got=%h want=%h", c, act, exp); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [38:0] act, exp;
        int left;
        for (int r = 0; r < 2; r++) begin
            do_reset(r);
            for (int c = 0; c < 300; c++) begin
                full = ($urandom_range(0, 3) == 0);
                for (int i = 0; i < nreq; i++)
                    if ($urandom_range(0, 3) == 0 && pq[i].size() < 4) pq[i].push_back($urandom);
                drive();
                step(act, exp);
                n_checks++;
                if (act !== exp) $display("FAIL rand%0d cyc%0d got=%h want=%h", r, c, act, exp); else n_pass++;
            end
            full = 1'b0; drive();
            for (int c = 0; c < 60; c++) begin
                step(act, exp);
                n_checks++;
                if (act !== exp) $display("FAIL rand%0d_drain cyc%0d got=%h want=%h", r, c, act, exp); else n_pass++;
            end
            left = pq[0].size() + pq[1].size() + pq[2].size();
            n_checks++;
            if (left !== 0) $display("FAIL rand%0d_left pending=%0d want 0", r, left); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_mask();
        test_prio0();
        test_reset_mid_issue();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
